// File: rtl/block_sync_rx.sv
// Interlaken word-lock stage: checks 64b/67b sync headers, drives gearbox SLIP until lock.
// Optional lock-loss statistics counter enabled by defining BLOCK_SYNC_STATS_EN.
module block_sync_rx #(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int ERR_LIMIT = 16,
    parameter int SLIP_WAIT = 32
) (
    input  logic        USER_CLK,
    input  logic        RESET_N,
    input  logic [66:0] DATA_IN,
    input  logic        DATA_VALID_IN,
    output logic [66:0] DATA_OUT,
    output logic        DATA_VALID_OUT,
    output logic        HDR_ERR,
    output logic        SLIP,
`ifdef BLOCK_SYNC_STATS_EN
    output logic        LOCKED,
    output logic [15:0] LOCK_LOSS_CNT
`else
    output logic        LOCKED
`endif
);

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LIMIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    if ((ERR_LIMIT > WINDOW) || (LOCK_CNT < 1) || (WINDOW < 1) ||
        (ERR_LIMIT < 1) || (SLIP_WAIT < 1)) begin : g_bad_params
        $error("block_sync_rx: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_HOLD = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t              state_r;
    logic [SH_W-1:0]     sh_cnt_r;
    logic [WIN_W-1:0]    win_cnt_r;
    logic [ERR_W-1:0]    err_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                hdr_bad_s;
    logic                lose_lock_s;

    // Only 01 and 10 are legal framing patterns.
    function automatic logic sync_hdr_ok(input logic [1:0] hdr);
        return (hdr == 2'b01) || (hdr == 2'b10);
    endfunction

    // Per-word header qualification and lock-loss decision.
    always_comb begin
        hdr_bad_s   = DATA_VALID_IN & ~sync_hdr_ok(DATA_IN[65:64]);
        lose_lock_s = 1'b0;
        if ((state_r == ST_LOCKED) && hdr_bad_s && (err_cnt_r == ERR_LAST)) begin
            lose_lock_s = 1'b1;
        end else begin
            lose_lock_s = 1'b0;
        end
    end

    // Word-lock state machine with registered datapath and status outputs.
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r        <= ST_SEARCH;
            sh_cnt_r       <= '0;
            win_cnt_r      <= '0;
            err_cnt_r      <= '0;
            wait_cnt_r     <= '0;
            DATA_OUT       <= 67'd0;
            DATA_VALID_OUT <= 1'b0;
            HDR_ERR        <= 1'b0;
            SLIP           <= 1'b0;
            LOCKED         <= 1'b0;
        end else begin
            SLIP           <= 1'b0;
            DATA_VALID_OUT <= DATA_VALID_IN & (state_r == ST_LOCKED);
            HDR_ERR        <= hdr_bad_s & (state_r != ST_SLIP_HOLD);
            if (DATA_VALID_IN) begin
                DATA_OUT <= DATA_IN;
            end
            case (state_r)
                ST_SEARCH: begin
                    if (hdr_bad_s) begin
                        sh_cnt_r   <= '0;
                        wait_cnt_r <= '0;
                        SLIP       <= 1'b1;
                        state_r    <= ST_SLIP_HOLD;
                    end else if (DATA_VALID_IN && (sh_cnt_r == SH_LAST)) begin
                        sh_cnt_r  <= '0;
                        win_cnt_r <= '0;
                        err_cnt_r <= '0;
                        LOCKED    <= 1'b1;
                        state_r   <= ST_LOCKED;
                    end else if (DATA_VALID_IN) begin
                        sh_cnt_r <= sh_cnt_r + SH_W'(1);
                    end
                end
                ST_SLIP_HOLD: begin
                    // Gearbox settling time: input is ignored, timer runs every cycle.
                    if (wait_cnt_r == WAIT_LAST) begin
                        wait_cnt_r <= '0;
                        sh_cnt_r   <= '0;
                        state_r    <= ST_SEARCH;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (lose_lock_s) begin
                        win_cnt_r  <= '0;
                        err_cnt_r  <= '0;
                        sh_cnt_r   <= '0;
                        wait_cnt_r <= '0;
                        LOCKED     <= 1'b0;
                        SLIP       <= 1'b1;
                        state_r    <= ST_SLIP_HOLD;
                    end else if (DATA_VALID_IN && (win_cnt_r == WIN_LAST)) begin
                        win_cnt_r <= '0;
                        err_cnt_r <= '0;
                    end else if (DATA_VALID_IN) begin
                        win_cnt_r <= win_cnt_r + WIN_W'(1);
                        if (hdr_bad_s) begin
                            err_cnt_r <= err_cnt_r + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_SEARCH;
                    sh_cnt_r   <= '0;
                    win_cnt_r  <= '0;
                    err_cnt_r  <= '0;
                    wait_cnt_r <= '0;
                    LOCKED     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BLOCK_SYNC_STATS_EN
    // Saturating count of LOCKED -> SLIP_HOLD transitions.
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            LOCK_LOSS_CNT <= 16'd0;
        end else if (lose_lock_s && (LOCK_LOSS_CNT != 16'hFFFF)) begin
            LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_block_sync_rx.sv
// Directed self-checking bench for block_sync_rx (default parameters).
module tb_block_sync_rx;

    logic        USER_CLK = 1'b0;
    logic        RESET_N;
    logic [66:0] DATA_IN;
    logic        DATA_VALID_IN;
    logic [66:0] DATA_OUT;
    logic        DATA_VALID_OUT;
    logic        HDR_ERR;
    logic        SLIP;
    logic        LOCKED;
`ifdef BLOCK_SYNC_STATS_EN
    logic [15:0] LOCK_LOSS_CNT;
`endif

    int errors = 0;
    int checks = 0;
    int slip_seen = 0;
    int herr_seen = 0;

    block_sync_rx dut (
        .USER_CLK      (USER_CLK),
        .RESET_N       (RESET_N),
        .DATA_IN       (DATA_IN),
        .DATA_VALID_IN (DATA_VALID_IN),
        .DATA_OUT      (DATA_OUT),
        .DATA_VALID_OUT(DATA_VALID_OUT),
        .HDR_ERR       (HDR_ERR),
        .SLIP          (SLIP),
`ifdef BLOCK_SYNC_STATS_EN
        .LOCKED        (LOCKED),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
`else
        .LOCKED        (LOCKED)
`endif
    );

    always #5 USER_CLK = ~USER_CLK;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check67(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given word applied; outputs sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic [1:0] hdr, input logic [63:0] pl);
        DATA_VALID_IN = v;
        DATA_IN       = {1'b0, hdr, pl};
        @(posedge USER_CLK);
        #1;
        slip_seen += int'(SLIP);
        herr_seen += int'(HDR_ERR);
    endtask

    initial begin
        RESET_N       = 1'b1;
        DATA_VALID_IN = 1'b0;
        DATA_IN       = 67'd0;
        #2 RESET_N = 1'b0;
        #1;
        check67("rst_data_out", DATA_OUT, 67'd0);
        check1("rst_dvo", DATA_VALID_OUT, 1'b0);
        check1("rst_hdr_err", HDR_ERR, 1'b0);
        check1("rst_slip", SLIP, 1'b0);
        check1("rst_locked", LOCKED, 1'b0);
`ifdef BLOCK_SYNC_STATS_EN
        checkn("rst_loss_cnt", int'(LOCK_LOSS_CNT), 0);
`endif
        @(posedge USER_CLK);
        @(posedge USER_CLK);
        #1 RESET_N = 1'b1;

        // Acquisition: 64 good words
        slip_seen = 0; herr_seen = 0;
        for (int i = 0; i < 63; i++) step(1'b1, 2'b01, 64'(i) + 64'h100);
        check1("acq_not_locked_63", LOCKED, 1'b0);
        step(1'b1, 2'b01, 64'h13F);
        check1("acq_locked_64", LOCKED, 1'b1);
        check1("acq_dvo_64", DATA_VALID_OUT, 1'b0);
        step(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0065);
        check1("acq_dvo_65", DATA_VALID_OUT, 1'b1);
        check67("acq_data_65", DATA_OUT, {1'b0, 2'b01, 64'hDEAD_BEEF_0000_0065});
        checkn("acq_no_slip", slip_seen, 0);
        checkn("acq_no_herr", herr_seen, 0);

        // First window (word 65 already counted): 15 bad in remaining 63
        herr_seen = 0;
        for (int i = 1; i < 64; i++) step(1'b1, (i <= 15) ? 2'b11 : 2'b10, 64'(i));
        checkn("win1_herr", herr_seen, 15);
        check1("win1_locked", LOCKED, 1'b1);

        // Second window: another 15 bad, must not unlock if window wrapped
        herr_seen = 0;
        for (int i = 0; i < 64; i++) step(1'b1, (i < 15) ? 2'b00 : 2'b01, 64'(i));
        checkn("win2_herr", herr_seen, 15);
        check1("win2_locked", LOCKED, 1'b1);
        check1("win2_dvo", DATA_VALID_OUT, 1'b1);
        checkn("win2_no_slip", slip_seen, 0);

        // Third window: 15 bad then 16th bad exactly on word 64
        for (int i = 0; i < 63; i++) step(1'b1, (i < 15) ? 2'b11 : 2'b01, 64'(i));
        check1("win3_locked_63", LOCKED, 1'b1);
        step(1'b1, 2'b11, 64'h40);
        check1("loss_locked", LOCKED, 1'b0);
        check1("loss_slip", SLIP, 1'b1);
        check1("loss_hdr_err", HDR_ERR, 1'b1);
        check1("loss_dvo_last", DATA_VALID_OUT, 1'b1);
`ifdef BLOCK_SYNC_STATS_EN
        checkn("loss_cnt_1", int'(LOCK_LOSS_CNT), 1);
`endif

        // SLIP_HOLD: 32 cycles of bad words are ignored
        slip_seen = 0; herr_seen = 0;
        for (int i = 0; i < 32; i++) step(1'b1, 2'b11, 64'(i));
        checkn("hold1_no_slip", slip_seen, 0);
        checkn("hold1_no_herr", herr_seen, 0);
        check1("hold1_dvo", DATA_VALID_OUT, 1'b0);

        // SEARCH: header 11 on word 10
        for (int i = 0; i < 9; i++) step(1'b1, 2'b01, 64'(i));
        check1("w10_pre_slip", SLIP, 1'b0);
        step(1'b1, 2'b11, 64'hA);
        check1("w10_slip", SLIP, 1'b1);
        check1("w10_hdr_err", HDR_ERR, 1'b1);
        slip_seen = 0; herr_seen = 0;
        for (int i = 0; i < 32; i++) step(1'b1, 2'b11, 64'(i));
        checkn("hold2_no_slip", slip_seen, 0);
        checkn("hold2_no_herr", herr_seen, 0);

        // Toggling DATA_VALID_IN: 64 valid words over 128 cycles
        slip_seen = 0; herr_seen = 0;
        for (int i = 0; i < 128; i++) begin
            step((i % 2) == 0, ((i % 2) == 0) ? 2'b01 : 2'b00, 64'(i));
            if (i == 124) check1("tog_not_locked", LOCKED, 1'b0);
            if (i == 126) begin
                check1("tog_locked", LOCKED, 1'b1);
                check1("tog_dvo_lockedge", DATA_VALID_OUT, 1'b0);
            end
        end
        check67("tog_data_hold", DATA_OUT, {1'b0, 2'b01, 64'd126});
        check1("tog_dvo_invalid", DATA_VALID_OUT, 1'b0);
        checkn("tog_no_herr", herr_seen, 0);
        checkn("tog_no_slip", slip_seen, 0);
        step(1'b1, 2'b10, 64'hA5);
        check1("tog_dvo_valid", DATA_VALID_OUT, 1'b1);

        // Asynchronous reset while locked
        RESET_N = 1'b0;
        #1;
        check1("arst_lock_locked", LOCKED, 1'b0);
        check1("arst_lock_dvo", DATA_VALID_OUT, 1'b0);
        check67("arst_lock_data", DATA_OUT, 67'd0);
        @(posedge USER_CLK);
        #1 RESET_N = 1'b1;
        step(1'b1, 2'b00, 64'h1);
        check1("arst_search_slip", SLIP, 1'b1);
`ifdef BLOCK_SYNC_STATS_EN
        checkn("arst_loss_cnt", int'(LOCK_LOSS_CNT), 0);
`endif

        // Asynchronous reset mid-SLIP_HOLD
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 64'h77);
        RESET_N = 1'b0;
        #1;
        check1("arst_hold_slip", SLIP, 1'b0);
        check1("arst_hold_herr", HDR_ERR, 1'b0);
        check1("arst_hold_locked", LOCKED, 1'b0);
        check67("arst_hold_data", DATA_OUT, 67'd0);
        @(posedge USER_CLK);
        #1 RESET_N = 1'b1;
        slip_seen = 0;
        for (int i = 0; i < 63; i++) step(1'b1, 2'b10, 64'(i));
        check1("post_rst_not_locked", LOCKED, 1'b0);
        step(1'b1, 2'b10, 64'h3F);
        check1("post_rst_locked", LOCKED, 1'b1);
        checkn("post_rst_no_slip", slip_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
